// File: rtl/sd_spi_response_transmitter.sv
// SPI-mode SD card response serializer.
// When the command decoder asks for a response, this block first drives
// NCR_BYTES filler bytes of 0xFF and then shifts out an R1 (8 bit) or
// R3/R7 (40 bit) response MSB-first, one bit per SPI clock.
// The module clock is SPI_CLK.
module sd_spi_response_transmitter #(
  parameter int NCR_BYTES = 1   // 0xFF filler bytes before the response, 0..8
) (
  input  logic        clock,
  input  logic        reset,          // asynchronous, active-low
  input  logic        io_SPI_CS,      // active-low chip select; high aborts
  input  logic        io_Start,
  input  logic        io_LongResp,
  input  logic [7:0]  io_R1,
  input  logic [31:0] io_Payload,
  output logic        io_SPI_DO,
  output logic        io_Busy,
  output logic        io_Done,
  output logic [1:0]  io____state,
  output logic [7:0]  io____counter
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NCR  = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  // Counter preloads; a zero filler count never uses NCR_LOAD.
  localparam logic [7:0] NCR_LOAD      = (NCR_BYTES > 0) ? 8'(8 * NCR_BYTES - 1) : 8'd0;
  localparam logic [7:0] SHORT_LEN_M1  = 8'd7;
  localparam logic [7:0] LONG_LEN_M1   = 8'd39;

  state_e      state_q;
  logic [7:0]  counter_q;
  logic [39:0] shift_q;
  logic [7:0]  len_m1_q;
  logic        do_q;
  logic        done_q;

  // Response frame latched at the Start edge, left-aligned so that bit 39
  // is always the next bit to go out; short responses are padded with 1s.
  logic [39:0] frame_d;
  logic [7:0]  len_m1_d;

  // Select the frame contents and length from the response type.
  always_comb begin
    frame_d  = io_LongResp ? {io_R1, io_Payload} : {io_R1, 32'hFFFF_FFFF};
    len_m1_d = io_LongResp ? LONG_LEN_M1 : SHORT_LEN_M1;
  end

  // Main sequencer: IDLE -> (NCR filler) -> SEND -> IDLE, with CS abort.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      counter_q <= 8'd0;
      shift_q   <= '1;
      len_m1_q  <= 8'd0;
      do_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          do_q <= 1'b1;
          if (io_Start && !io_SPI_CS) begin
            shift_q  <= frame_d;
            len_m1_q <= len_m1_d;
            if (NCR_BYTES > 0) begin
              state_q   <= ST_NCR;
              counter_q <= NCR_LOAD;
            end else begin
              // No filler: the first response bit leaves on this very edge.
              state_q   <= ST_SEND;
              counter_q <= len_m1_d;
              do_q      <= io_R1[7];
            end
          end
        end

        ST_NCR: begin
          if (io_SPI_CS) begin
            state_q   <= ST_IDLE;
            counter_q <= 8'd0;
            shift_q   <= '1;
            do_q      <= 1'b1;
          end else if (counter_q == 8'd0) begin
            state_q   <= ST_SEND;
            counter_q <= len_m1_q;
            do_q      <= shift_q[39];
          end else begin
            counter_q <= counter_q - 8'd1;
            do_q      <= 1'b1;
          end
        end

        ST_SEND: begin
          if (io_SPI_CS) begin
            state_q   <= ST_IDLE;
            counter_q <= 8'd0;
            shift_q   <= '1;
            do_q      <= 1'b1;
          end else if (counter_q == 8'd0) begin
            state_q <= ST_IDLE;
            shift_q <= '1;
            do_q    <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            shift_q   <= {shift_q[38:0], 1'b1};
            do_q      <= shift_q[38];
            counter_q <= counter_q - 8'd1;
          end
        end

        default: begin
          state_q   <= ST_IDLE;
          counter_q <= 8'd0;
          shift_q   <= '1;
          do_q      <= 1'b1;
        end
      endcase
    end
  end

  // Outputs come straight from registers; Busy decodes the state.
  always_comb begin
    io_SPI_DO     = do_q;
    io_Done       = done_q;
    io_Busy       = (state_q != ST_IDLE);
    io____state   = state_q;
    io____counter = counter_q;
  end

endmodule

// File: tb/tb_sd_spi_response_transmitter.sv
// Scoreboard bench for sd_spi_response_transmitter. Two instances are used:
// one with a single filler byte, one with none. The driver pushes the
// expected DO stream for each accepted frame; a negedge monitor collects
// the DO bits while Busy and compares the stream at each Done pulse.
module tb_sd_spi_response_transmitter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  cs_v;
  logic [1:0]  start_v;
  logic        long_v;
  logic [7:0]  r1_v;
  logic [31:0] pay_v;
  logic [1:0]  do_v, busy_v, done_v;
  logic [1:0]  state0, state1;
  logic [7:0]  cnt0, cnt1;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int           nbits;
    logic [103:0] bits;
    int           done_cyc;
  } frame_t;

  frame_t q0[$];
  frame_t q1[$];

  logic [103:0] got_bits[2];
  int           got_n[2];
  logic         busy_prev[2];

  sd_spi_response_transmitter #(.NCR_BYTES(1)) dut0 (
    .clock(clk), .reset(reset), .io_SPI_CS(cs_v[0]), .io_Start(start_v[0]),
    .io_LongResp(long_v), .io_R1(r1_v), .io_Payload(pay_v),
    .io_SPI_DO(do_v[0]), .io_Busy(busy_v[0]), .io_Done(done_v[0]),
    .io____state(state0), .io____counter(cnt0)
  );

  sd_spi_response_transmitter #(.NCR_BYTES(0)) dut1 (
    .clock(clk), .reset(reset), .io_SPI_CS(cs_v[1]), .io_Start(start_v[1]),
    .io_LongResp(long_v), .io_R1(r1_v), .io_Payload(pay_v),
    .io_SPI_DO(do_v[1]), .io_Busy(busy_v[1]), .io_Done(done_v[1]),
    .io____state(state1), .io____counter(cnt1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string nm, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, got, exp);
    end
  endtask

  // Reference: filler ones, then the response bits MSB first; Done lands
  // 8*NCR + L edges after the Start edge.
  function automatic frame_t model(int nbytes, bit lng, logic [7:0] r1,
                                   logic [31:0] p, int s);
    frame_t      f;
    logic [39:0] resp;
    int          len;
    int          n;
    resp   = {r1, p};
    len    = lng ? 40 : 8;
    f.bits = '0;
    n      = 0;
    for (int i = 0; i < 8 * nbytes; i++) begin
      f.bits[n] = 1'b1;
      n++;
    end
    for (int j = 0; j < len; j++) begin
      f.bits[n] = resp[39 - j];
      n++;
    end
    f.nbits    = n;
    f.done_cyc = s + 8 * nbytes + len;
    return f;
  endfunction

  task automatic push_frame(int k, frame_t f);
    if (k == 0) q0.push_back(f);
    else        q1.push_back(f);
  endtask

  task automatic mon_step(int k);
    frame_t f;
    bit     have;
    if (busy_v[k]) begin
      if (got_n[k] < 104) got_bits[k][got_n[k]] = do_v[k];
      got_n[k]++;
    end
    if (done_v[k]) begin
      have = 0;
      if (k == 0 && q0.size() > 0) begin f = q0.pop_front(); have = 1; end
      if (k == 1 && q1.size() > 0) begin f = q1.pop_front(); have = 1; end
      checks++;
      if (!have) begin
        errors++;
        $display("FAIL dut%0d_unexpected_done: got Done at cycle %0d required none", k, cyc);
      end else begin
        check($sformatf("dut%0d_nbits", k), 64'(got_n[k]), 64'(f.nbits));
        checks++;
        if (got_bits[k] !== f.bits) begin
          errors++;
          $display("FAIL dut%0d_stream: got %h required %h", k, got_bits[k], f.bits);
        end
        check($sformatf("dut%0d_done_cycle", k), 64'(cyc), 64'(f.done_cyc));
        check($sformatf("dut%0d_busy_at_done", k), 64'(busy_v[k]), 64'd0);
        $display("frame dut%0d done at cycle %0d bits=%0d", k, cyc, got_n[k]);
      end
      got_n[k]    = 0;
      got_bits[k] = '0;
    end else if (busy_prev[k] && !busy_v[k]) begin
      $display("frame dut%0d ended without Done at cycle %0d", k, cyc);
      got_n[k]    = 0;
      got_bits[k] = '0;
    end
    busy_prev[k] = busy_v[k];
  endtask

  always @(negedge clk) begin
    mon_step(0);
    mon_step(1);
  end

  task automatic check_idle(int k, string tag);
    check($sformatf("%s_do", tag), 64'(do_v[k]), 64'd1);
    check($sformatf("%s_busy", tag), 64'(busy_v[k]), 64'd0);
    check($sformatf("%s_state", tag), 64'((k == 0) ? state0 : state1), 64'd0);
    check($sformatf("%s_counter", tag), 64'((k == 0) ? cnt0 : cnt1), 64'd0);
  endtask

  // One Start pulse; abort_at>0 raises CS at that edge offset after the
  // Start edge; noise toggles Start and the data inputs while busy.
  task automatic run_frame(int k, bit lng, logic [7:0] r1, logic [31:0] p,
                           int abort_at, bit noise);
    int nb;
    int total;
    int s;
    nb    = (k == 0) ? 1 : 0;
    total = 8 * nb + (lng ? 40 : 8);
    @(negedge clk);
    long_v     = lng;
    r1_v       = r1;
    pay_v      = p;
    cs_v[k]    = 1'b0;
    start_v[k] = 1'b1;
    s          = cyc + 1;
    if (abort_at == 0) push_frame(k, model(nb, lng, r1, p, s));
    for (int i = 1; i <= total + 3; i++) begin
      @(negedge clk);
      start_v[k] = (noise && i <= total) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise && i <= total) begin
        r1_v   = 8'($urandom);
        pay_v  = $urandom;
        long_v = 1'($urandom);
      end
      if (abort_at != 0 && i >= abort_at) cs_v[k] = 1'b1;
    end
    if (abort_at != 0) begin
      check_idle(k, $sformatf("dut%0d_after_abort", k));
      @(negedge clk);
      cs_v[k] = 1'b0;
    end
  endtask

  initial begin
    reset   = 1'b0;
    cs_v    = 2'b00;
    start_v = 2'b00;
    long_v  = 1'b0;
    r1_v    = 8'h00;
    pay_v   = 32'h0;
    for (int k = 0; k < 2; k++) begin
      got_n[k]     = 0;
      got_bits[k]  = '0;
      busy_prev[k] = 1'b0;
    end
    #12;
    check_idle(0, "reset0");
    check_idle(1, "reset1");
    check("reset0_done", 64'(done_v[0]), 64'd0);
    check("reset1_done", 64'(done_v[1]), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // R1 = 0x01 with one filler byte
    run_frame(0, 1'b0, 8'h01, 32'h0, 0, 1'b0);
    // R7 = 0x01_000001AA
    run_frame(0, 1'b1, 8'h01, 32'h0000_01AA, 0, 1'b0);
    // CS high on the edge after the 5th SEND bit, then a clean resend
    run_frame(0, 1'b1, 8'h01, 32'h0000_01AA, 13, 1'b0);
    run_frame(0, 1'b1, 8'h01, 32'h0000_01AA, 0, 1'b0);
    // Start and data wiggling while busy must not disturb the frame
    run_frame(0, 1'b0, 8'h01, 32'h0, 0, 1'b1);
    // No filler: R1 = 0x00
    run_frame(1, 1'b0, 8'h00, 32'h0, 0, 1'b0);

    // Held Start: ignored on the Done edge, accepted on the following one
    begin
      int s;
      @(negedge clk);
      long_v     = 1'b0;
      r1_v       = 8'h00;
      pay_v      = 32'h0;
      cs_v[1]    = 1'b0;
      start_v[1] = 1'b1;
      s          = cyc + 1;
      push_frame(1, model(0, 1'b0, 8'h00, 32'h0, s));
      push_frame(1, model(0, 1'b0, 8'h00, 32'h0, s + 9));
      repeat (10) @(negedge clk);
      start_v[1] = 1'b0;
      repeat (12) @(negedge clk);
    end

    // Asynchronous reset in the middle of the filler phase
    begin
      @(negedge clk);
      long_v     = 1'b1;
      r1_v       = 8'h3C;
      pay_v      = 32'hDEAD_BEEF;
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      check("ncr_state", 64'(state0), 64'd1);
      check("ncr_counter", 64'(cnt0), 64'd7);
      check("ncr_busy", 64'(busy_v[0]), 64'd1);
      check("ncr_do", 64'(do_v[0]), 64'd1);
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check_idle(0, "async_reset");
      check("async_reset_done", 64'(done_v[0]), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (12) @(negedge clk);
      check_idle(0, "post_reset");
    end

    // Randomized traffic on both instances
    for (int n = 0; n < 40; n++) begin
      int  k;
      bit  lng;
      int  total;
      int  ab;
      k     = int'($urandom_range(0, 1));
      lng   = 1'($urandom);
      total = ((k == 0) ? 8 : 0) + (lng ? 40 : 8);
      ab    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, total - 1)) : 0;
      run_frame(k, lng, 8'($urandom), $urandom, ab, 1'($urandom));
    end

    repeat (4) @(negedge clk);
    check("dut0_queue_empty", 64'(q0.size()), 64'd0);
    check("dut1_queue_empty", 64'(q1.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
